// File: rtl/alu_iterative_exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the iterative execute-stage ALU:
//               ALU control codes, FSM state encoding and the flag bundle.
//               Build option ALU_BARREL_SHIFT_EN selects combinational shifts.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU control codes as produced by the ALU decoder
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    // Execution FSM states
    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_SHIFT = 2'd1,
        STATE_DONE  = 2'd2
    } alu_state_e;

    // Result flags travelling with every result
    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic overflow;
    } alu_flags_t;

    // True for the three shift operations
    function automatic logic alu_is_shift(input logic [3:0] ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_iterative_exec_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_iterative_exec_if
// Description : Operand/result handshake bundle of the iterative ALU.
//               slave = ALU side, master = pipeline side.
//               Build option ALU_BARREL_SHIFT_EN does not change this bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_iterative_exec_if #(
    parameter int WIDTH = 32
);
    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [3:0]       alu_control_i;
    logic [WIDTH-1:0] src_a_i;
    logic [WIDTH-1:0] src_b_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             neg_o;
    logic             carry_o;
    logic             overflow_o;
    logic             busy_o;

    modport slave (
        input  flush_i, in_valid_i, alu_control_i, src_a_i, src_b_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, zero_o, neg_o, carry_o,
               overflow_o, busy_o
    );

    modport master (
        output flush_i, in_valid_i, alu_control_i, src_a_i, src_b_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, zero_o, neg_o, carry_o,
               overflow_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/alu_iterative_exec_shifter.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_shifter
// Description : One-bit-per-cycle shifter (SLL/SRL/SRA). i_start loads the
//               working register and a non-zero shift count; o_done flags the
//               cycle whose edge writes the final shift, with o_result being
//               that final value. Not instantiated under ALU_BARREL_SHIFT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               i_flush,
    input  wire logic               i_start,
    input  wire logic [3:0]         i_op,
    input  wire logic [WIDTH-1:0]   i_data,
    input  wire logic [SHAMT_W-1:0] i_shamt,
    output logic                    o_done,
    output logic [WIDTH-1:0]        o_result
);

    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W-1:0] r_count;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   w_shifted;

    // Single-position shift with the fill bit chosen by the operation
    always_comb begin
        w_shifted = r_work;
        case (r_op)
            ALU_SLL: w_shifted = {r_work[WIDTH-2:0], 1'b0};
            ALU_SRL: w_shifted = {1'b0, r_work[WIDTH-1:1]};
            ALU_SRA: w_shifted = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
            default: w_shifted = r_work;
        endcase
    end

    assign o_done   = (r_count == SHAMT_W'(1));
    assign o_result = w_shifted;

    // Load on start, then shift and count down until the counter empties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work  <= '0;
            r_count <= '0;
            r_op    <= ALU_SLL;
        end else if (i_flush) begin
            r_count <= '0;
        end else if (i_start) begin
            r_work  <= i_data;
            r_count <= i_shamt;
            r_op    <= i_op;
        end else if (r_count != '0) begin
            r_work  <= w_shifted;
            r_count <= r_count - SHAMT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_iterative_exec.sv
`default_nettype none
// ============================================================================
// Module      : alu_iterative_exec
// Description : Execute-stage ALU with valid/ready handshake. ADD/SUB/logic/
//               compare ops take one cycle; shifts run serially one bit per
//               cycle (latency shamt+1). Defining ALU_BARREL_SHIFT_EN makes
//               shifts combinational (latency 1) and removes the shifter.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_iterative_exec
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  wire logic        clk_i,
    input  wire logic        reset_n_i,
    alu_iterative_exec_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'(STATE_IDLE);
    localparam logic [1:0] S_SHIFT = 2'(STATE_SHIFT);
    localparam logic [1:0] S_DONE  = 2'(STATE_DONE);

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_result;
    alu_flags_t         r_flags;

    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic               w_slt;
    logic               w_sltu;
    logic [WIDTH-1:0]   w_res;
    alu_flags_t         w_flags;
    logic               w_known;
    logic               w_accept;
    logic               w_go_serial;

    assign w_a     = bus.src_a_i;
    assign w_b     = bus.src_b_i;
    assign w_shamt = bus.src_b_i[SHAMT_W-1:0];

    // Carry and overflow come from a WIDTH+1-bit add; SUB adds ~b + 1
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff = {1'b0, w_a} + {1'b0, ~w_b} + {{WIDTH{1'b0}}, 1'b1};
    assign w_slt  = ($signed(w_a) < $signed(w_b));
    assign w_sltu = (w_a < w_b);

    // Single-cycle result and flags for the op presented in IDLE
    always_comb begin
        w_res   = '0;
        w_flags = '0;
        w_known = 1'b1;
        case (bus.alu_control_i)
            ALU_ADD: begin
                w_res            = w_sum[WIDTH-1:0];
                w_flags.carry    = w_sum[WIDTH];
                w_flags.overflow = (w_a[WIDTH-1] == w_b[WIDTH-1]) &&
                                   (w_sum[WIDTH-1] != w_a[WIDTH-1]);
            end
            ALU_SUB: begin
                w_res            = w_diff[WIDTH-1:0];
                w_flags.carry    = w_diff[WIDTH];
                w_flags.overflow = (w_a[WIDTH-1] != w_b[WIDTH-1]) &&
                                   (w_diff[WIDTH-1] != w_a[WIDTH-1]);
            end
            ALU_AND:  w_res = w_a & w_b;
            ALU_OR:   w_res = w_a | w_b;
            ALU_XOR:  w_res = w_a ^ w_b;
            ALU_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_slt};
            ALU_SLTU: w_res = {{(WIDTH-1){1'b0}}, w_sltu};
`ifdef ALU_BARREL_SHIFT_EN
            ALU_SLL:  w_res = w_a << w_shamt;
            ALU_SRL:  w_res = w_a >> w_shamt;
            ALU_SRA:  w_res = $unsigned($signed(w_a) >>> w_shamt);
`else
            // Only reached with shamt == 0; non-zero amounts go serial
            ALU_SLL, ALU_SRL, ALU_SRA: w_res = w_a;
`endif
            default: w_known = 1'b0;
        endcase
        if (w_known) begin
            w_flags.zero = (w_res == '0);
            w_flags.neg  = w_res[WIDTH-1];
        end
    end

    assign w_accept = (r_state == S_IDLE) && bus.in_valid_i && !bus.flush_i;

`ifdef ALU_BARREL_SHIFT_EN
    assign w_go_serial = 1'b0;
`else
    logic             w_sh_done;
    logic [WIDTH-1:0] w_sh_result;

    assign w_go_serial = alu_is_shift(bus.alu_control_i) && (w_shamt != '0);

    alu_serial_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk      (clk_i),
        .rst_n    (reset_n_i),
        .i_flush  (bus.flush_i),
        .i_start  (w_accept && w_go_serial),
        .i_op     (bus.alu_control_i),
        .i_data   (w_a),
        .i_shamt  (w_shamt),
        .o_done   (w_sh_done),
        .o_result (w_sh_result)
    );
`endif

    // Control FSM; flush overrides everything except reset
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_flags  <= '0;
        end else if (bus.flush_i) begin
            r_state  <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_go_serial) begin
                            r_state <= S_SHIFT;
                        end else begin
                            r_state  <= S_DONE;
                            r_result <= w_res;
                            r_flags  <= w_flags;
                        end
                    end
                end
`ifndef ALU_BARREL_SHIFT_EN
                S_SHIFT: begin
                    if (w_sh_done) begin
                        r_state        <= S_DONE;
                        r_result       <= w_sh_result;
                        r_flags        <= '0;
                        r_flags.zero   <= (w_sh_result == '0);
                        r_flags.neg    <= w_sh_result[WIDTH-1];
                    end
                end
`endif
                S_DONE: begin
                    if (bus.out_ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready_o  = (r_state == S_IDLE);
    assign bus.out_valid_o = (r_state == S_DONE);
    assign bus.busy_o      = (r_state != S_IDLE);
    assign bus.result_o    = r_result;
    assign bus.zero_o      = r_flags.zero;
    assign bus.neg_o       = r_flags.neg;
    assign bus.carry_o     = r_flags.carry;
    assign bus.overflow_o  = r_flags.overflow;

endmodule
`default_nettype wire
